// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates the instruction-fetch and data-access request streams of the
//   pipelined core onto one single-ported RAM, one transaction at a time.
//   Data has priority; after STARVE_LIMIT consecutive data grants taken while
//   fetch was waiting, fetch wins once (STARVE_LIMIT = 0 disables this).
//   A serve state lasting TIMEOUT cycles without ram_ack is aborted, returns
//   32'hBAD1BAD1 as read data and sets the sticky bus_err flag.
//
// Ports
//   CLK, nRST          clock (rising edge), asynchronous active-low reset
//   iREN, iaddr        fetch read request / word address
//   iwait, iload       fetch not complete this cycle / fetch read data
//   dREN, dWEN         data read / write request (write wins if both)
//   daddr, dstore      data address / write value
//   dwait, dload       data access not complete this cycle / data read data
//   ram_addr/ram_store RAM address / write data (registered)
//   ram_ren/ram_wen    RAM read / write strobes (high for the whole serve state)
//   ram_load, ram_ack  RAM read data / access complete this cycle
//   bus_err            sticky: a transaction timed out
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_store,
  output logic        ram_ren,
  output logic        ram_wen,
  input  logic [31:0] ram_load,
  input  logic        ram_ack,
  output logic        bus_err
);

  localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [SW-1:0] SMAX = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0] SONE = SW'(1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
  localparam logic [TW-1:0] TONE = TW'(1);
  localparam logic [31:0]   ERR_WORD = 32'hBAD1BAD1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISERV = 2'd1,
    DSERV = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [SW-1:0] r_scnt;
  logic [TW-1:0] r_tcnt;
  logic          r_ren;
  logic          r_wen;
  logic          r_err;
  logic [31:0]   r_addr;
  logic [31:0]   r_store;

  logic w_dreq;
  logic w_fetch_turn;
  logic w_dgrant;
  logic w_igrant;
  logic w_serve;
  logic w_tmax;
  logic w_done;
  logic w_timeout;

  assign w_dreq       = dREN | dWEN;
  // Fetch has waited through STARVE_LIMIT data grants: it takes this slot.
  assign w_fetch_turn = (STARVE_LIMIT > 0) && (r_scnt == SMAX) && iREN;
  assign w_dgrant     = (r_state == IDLE) && w_dreq && !w_fetch_turn;
  assign w_igrant     = (r_state == IDLE) && iREN && !w_dgrant;
  assign w_serve      = (r_state != IDLE);
  assign w_tmax       = (r_tcnt == TMAX);
  assign w_done       = w_serve && (ram_ack || w_tmax);
  // ack in the same cycle as the limit is a normal completion
  assign w_timeout    = w_serve && w_tmax && !ram_ack;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    iwait  = 1'b0;
    dwait  = 1'b0;
    iload  = '0;
    dload  = '0;

    unique case (r_state)
      IDLE: begin
        if (w_dgrant) begin
          w_next = DSERV;
        end else if (w_igrant) begin
          w_next = ISERV;
        end
      end
      ISERV, DSERV: begin
        if (ram_ack || w_tmax) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase

    iwait = iREN   && !((r_state == ISERV) && (ram_ack || w_tmax));
    dwait = w_dreq && !((r_state == DSERV) && (ram_ack || w_tmax));

    if (r_state == ISERV) begin
      if (ram_ack) begin
        iload = ram_load;
      end else if (w_tmax) begin
        iload = ERR_WORD;
      end
    end
    if (r_state == DSERV) begin
      if (ram_ack) begin
        dload = ram_load;
      end else if (w_tmax) begin
        dload = ERR_WORD;
      end
    end
  end

  // RAM-side registers, starvation and timeout counters. Strobes are set on
  // the grant edge and cleared on the completing edge, so they track the
  // serve state exactly and drop immediately on reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_addr  <= '0;
      r_store <= '0;
      r_ren   <= 1'b0;
      r_wen   <= 1'b0;
      r_scnt  <= '0;
      r_tcnt  <= '0;
      r_err   <= 1'b0;
    end else if (w_dgrant) begin
      r_addr  <= daddr;
      r_store <= dstore;
      r_wen   <= dWEN;
      r_ren   <= !dWEN;
      r_tcnt  <= '0;
      if (!iREN) begin
        r_scnt <= '0;
      end else if (r_scnt != SMAX) begin
        r_scnt <= r_scnt + SONE;
      end
    end else if (w_igrant) begin
      r_addr  <= iaddr;
      r_store <= '0;
      r_wen   <= 1'b0;
      r_ren   <= 1'b1;
      r_tcnt  <= '0;
      r_scnt  <= '0;
    end else if (w_done) begin
      r_ren <= 1'b0;
      r_wen <= 1'b0;
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end else if (w_serve) begin
      r_tcnt <= r_tcnt + TONE;
    end
  end

  assign ram_addr  = r_addr;
  assign ram_store = r_store;
  assign ram_ren   = r_ren;
  assign ram_wen   = r_wen;
  assign bus_err   = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter. Instance u_a uses STARVE_LIMIT=4 and
//   TIMEOUT=8; instance u_b shares all request inputs but uses STARVE_LIMIT=0
//   to show pure data priority. ram_ack is either driven by hand or, when
//   auto_ack is set, returned in the first serve cycle (2-cycle latency).
module tb_mem_arbiter;

  logic        CLK;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ram_load;
  logic        man_ack, auto_ack;

  logic        iwait_a, dwait_a, ram_ren_a, ram_wen_a, ram_ack_a, bus_err_a;
  logic [31:0] iload_a, dload_a, ram_addr_a, ram_store_a;
  logic        iwait_b, dwait_b, ram_ren_b, ram_wen_b, ram_ack_b, bus_err_b;
  logic [31:0] iload_b, dload_b, ram_addr_b, ram_store_b;

  int n_cmp;
  int n_fail;

  assign ram_ack_a = auto_ack ? (ram_ren_a | ram_wen_a) : man_ack;
  assign ram_ack_b = auto_ack ? (ram_ren_b | ram_wen_b) : man_ack;

  mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(8)) u_a (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait_a), .iload(iload_a),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait_a), .dload(dload_a),
    .ram_addr(ram_addr_a), .ram_store(ram_store_a),
    .ram_ren(ram_ren_a), .ram_wen(ram_wen_a),
    .ram_load(ram_load), .ram_ack(ram_ack_a), .bus_err(bus_err_a)
  );

  mem_arbiter #(.STARVE_LIMIT(0), .TIMEOUT(8)) u_b (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait_b), .iload(iload_b),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait_b), .dload(dload_b),
    .ram_addr(ram_addr_b), .ram_store(ram_store_b),
    .ram_ren(ram_ren_b), .ram_wen(ram_wen_b),
    .ram_load(ram_load), .ram_ack(ram_ack_b), .bus_err(bus_err_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Returns 1 time unit after a rising edge, out of reset, inputs idle.
  task automatic apply_reset;
    iREN = 0; dREN = 0; dWEN = 0; iaddr = '0; daddr = '0; dstore = '0;
    ram_load = '0; man_ack = 0; auto_ack = 0;
    nRST = 0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1;
  endtask

  task automatic test_reset;
    apply_reset();
    @(negedge CLK);
    n_cmp++; if (ram_ren_a !== 1'b0) begin n_fail++; $display("FAIL rst_ren: got %b want 0", ram_ren_a); end
    n_cmp++; if (ram_wen_a !== 1'b0) begin n_fail++; $display("FAIL rst_wen: got %b want 0", ram_wen_a); end
    n_cmp++; if (ram_addr_a !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", ram_addr_a); end
    n_cmp++; if (ram_store_a !== 32'h0) begin n_fail++; $display("FAIL rst_store: got %h want 0", ram_store_a); end
    n_cmp++; if (bus_err_a !== 1'b0) begin n_fail++; $display("FAIL rst_buserr: got %b want 0", bus_err_a); end
    // reset in the middle of a data write
    dWEN = 1; daddr = 32'h10; dstore = 32'h55;
    @(negedge CLK);
    n_cmp++; if (dwait_a !== 1'b1) begin n_fail++; $display("FAIL rst_idle_dwait: got %b want 1", dwait_a); end
    @(negedge CLK);
    n_cmp++; if (ram_wen_a !== 1'b1) begin n_fail++; $display("FAIL rst_dserv_wen: got %b want 1", ram_wen_a); end
    #2 nRST = 0;
    #1;
    n_cmp++; if (ram_wen_a !== 1'b0) begin n_fail++; $display("FAIL rst_async_wen: got %b want 0", ram_wen_a); end
    n_cmp++; if (ram_ren_a !== 1'b0) begin n_fail++; $display("FAIL rst_async_ren: got %b want 0", ram_ren_a); end
    n_cmp++; if (bus_err_a !== 1'b0) begin n_fail++; $display("FAIL rst_async_buserr: got %b want 0", bus_err_a); end
    dWEN = 0;
    @(posedge CLK);
    #1 nRST = 1;
    dREN = 1; daddr = 32'h20;
    // a single edge from reset grants the read, so the FSM restarted in IDLE
    @(posedge CLK); #1;
    n_cmp++; if (ram_ren_a !== 1'b1) begin n_fail++; $display("FAIL rst_regrant_ren: got %b want 1", ram_ren_a); end
    n_cmp++; if (ram_addr_a !== 32'h20) begin n_fail++; $display("FAIL rst_regrant_addr: got %h want 00000020", ram_addr_a); end
  endtask

  task automatic test_lone_fetch;
    apply_reset();
    iREN = 1; iaddr = 32'h40;
    @(negedge CLK);
    n_cmp++; if (iwait_a !== 1'b1) begin n_fail++; $display("FAIL fetch_wait_idle: got %b want 1", iwait_a); end
    @(posedge CLK); #1;
    man_ack = 1; ram_load = 32'h8C010004;
    @(negedge CLK);
    n_cmp++; if (iwait_a !== 1'b0) begin n_fail++; $display("FAIL fetch_wait_ack: got %b want 0", iwait_a); end
    n_cmp++; if (iload_a !== 32'h8C010004) begin n_fail++; $display("FAIL fetch_load: got %h want 8c010004", iload_a); end
    n_cmp++; if (ram_addr_a !== 32'h40) begin n_fail++; $display("FAIL fetch_addr: got %h want 00000040", ram_addr_a); end
    n_cmp++; if (ram_ren_a !== 1'b1) begin n_fail++; $display("FAIL fetch_ren: got %b want 1", ram_ren_a); end
    @(posedge CLK); #1;
    man_ack = 0;
    @(negedge CLK);
    n_cmp++; if (iwait_a !== 1'b1) begin n_fail++; $display("FAIL fetch_wait_after: got %b want 1", iwait_a); end
    n_cmp++; if (ram_ren_a !== 1'b0) begin n_fail++; $display("FAIL fetch_idle_ren: got %b want 0", ram_ren_a); end
    n_cmp++; if (iload_a !== 32'h0) begin n_fail++; $display("FAIL fetch_idle_load: got %h want 0", iload_a); end
  endtask

  task automatic test_priority;
    apply_reset();
    iREN = 1; iaddr = 32'h40; dREN = 1; daddr = 32'h100;
    @(posedge CLK); #1;
    n_cmp++; if (ram_addr_a !== 32'h100) begin n_fail++; $display("FAIL prio_first_addr: got %h want 00000100", ram_addr_a); end
    man_ack = 1; ram_load = 32'h11112222;
    @(negedge CLK);
    n_cmp++; if (dwait_a !== 1'b0) begin n_fail++; $display("FAIL prio_dwait: got %b want 0", dwait_a); end
    n_cmp++; if (iwait_a !== 1'b1) begin n_fail++; $display("FAIL prio_iwait_held: got %b want 1", iwait_a); end
    n_cmp++; if (dload_a !== 32'h11112222) begin n_fail++; $display("FAIL prio_dload: got %h want 11112222", dload_a); end
    @(posedge CLK); #1;
    dREN = 0; man_ack = 0;
    @(negedge CLK);
    n_cmp++; if (ram_ren_a !== 1'b0) begin n_fail++; $display("FAIL prio_gap_ren: got %b want 0", ram_ren_a); end
    n_cmp++; if (iwait_a !== 1'b1) begin n_fail++; $display("FAIL prio_gap_iwait: got %b want 1", iwait_a); end
    @(posedge CLK); #1;
    n_cmp++; if (ram_addr_a !== 32'h40) begin n_fail++; $display("FAIL prio_second_addr: got %h want 00000040", ram_addr_a); end
    man_ack = 1; ram_load = 32'h33334444;
    @(negedge CLK);
    n_cmp++; if (iload_a !== 32'h33334444) begin n_fail++; $display("FAIL prio_iload: got %h want 33334444", iload_a); end
    @(posedge CLK); #1;
    iREN = 0; man_ack = 0;
  endtask

  task automatic test_write_wins;
    apply_reset();
    dREN = 1; dWEN = 1; daddr = 32'h200; dstore = 32'hDEAD;
    @(negedge CLK);
    @(negedge CLK);
    n_cmp++; if (ram_wen_a !== 1'b1) begin n_fail++; $display("FAIL wr_wen: got %b want 1", ram_wen_a); end
    n_cmp++; if (ram_ren_a !== 1'b0) begin n_fail++; $display("FAIL wr_ren: got %b want 0", ram_ren_a); end
    n_cmp++; if (ram_store_a !== 32'hDEAD) begin n_fail++; $display("FAIL wr_store: got %h want 0000dead", ram_store_a); end
    n_cmp++; if (ram_addr_a !== 32'h200) begin n_fail++; $display("FAIL wr_addr: got %h want 00000200", ram_addr_a); end
    #1 man_ack = 1;
    @(posedge CLK); #1;
    dREN = 0; dWEN = 0; man_ack = 0;
  endtask

  task automatic test_starvation;
    bit exp_i[10];
    bit got_i[10];
    int na, nb_i, nb_d;
    exp_i = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    got_i = '{default: 0};
    na = 0; nb_i = 0; nb_d = 0;
    apply_reset();
    auto_ack = 1;
    dWEN = 1; daddr = 32'h300; dstore = 32'h77; iREN = 1; iaddr = 32'h80;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (ram_ren_a | ram_wen_a) begin
        if (na < 10) got_i[na] = ram_ren_a;
        na++;
      end
      if (ram_ren_b) nb_i++;
      if (ram_wen_b) nb_d++;
    end
    #1 dWEN = 0; iREN = 0;
    n_cmp++; if (na !== 10) begin n_fail++; $display("FAIL starve_count: got %0d want 10", na); end
    for (int k = 0; k < 10; k++) begin
      n_cmp++; if (got_i[k] !== exp_i[k]) begin n_fail++; $display("FAIL starve_slot%0d: got fetch=%0d want fetch=%0d", k, got_i[k], exp_i[k]); end
    end
    n_cmp++; if (nb_i !== 0) begin n_fail++; $display("FAIL nostarve_fetch: got %0d want 0", nb_i); end
    n_cmp++; if (nb_d !== 10) begin n_fail++; $display("FAIL nostarve_data: got %0d want 10", nb_d); end
    @(posedge CLK); #1;
    auto_ack = 0;
  endtask

  task automatic test_timeout;
    apply_reset();
    // ack arriving exactly at the limit completes normally
    iREN = 1; iaddr = 32'h44;
    for (int c = 1; c <= 9; c++) begin
      @(posedge CLK); #1;
      if (c == 9) begin man_ack = 1; ram_load = 32'h12345678; end
    end
    @(negedge CLK);
    n_cmp++; if (iwait_a !== 1'b0) begin n_fail++; $display("FAIL tie_iwait: got %b want 0", iwait_a); end
    n_cmp++; if (iload_a !== 32'h12345678) begin n_fail++; $display("FAIL tie_iload: got %h want 12345678", iload_a); end
    @(posedge CLK); #1;
    iREN = 0; man_ack = 0;
    @(negedge CLK);
    n_cmp++; if (bus_err_a !== 1'b0) begin n_fail++; $display("FAIL tie_buserr: got %b want 0", bus_err_a); end
    // no ack at all: abort after TIMEOUT serve cycles
    dREN = 1; daddr = 32'h400;
    for (int c = 1; c <= 9; c++) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      n_cmp++; if (ram_ren_a !== 1'b1) begin n_fail++; $display("FAIL to_ren_c%0d: got %b want 1", c, ram_ren_a); end
      if (c < 9) begin
        n_cmp++; if (dwait_a !== 1'b1) begin n_fail++; $display("FAIL to_dwait_c%0d: got %b want 1", c, dwait_a); end
      end else begin
        n_cmp++; if (dwait_a !== 1'b0) begin n_fail++; $display("FAIL to_dwait_end: got %b want 0", dwait_a); end
        n_cmp++; if (dload_a !== 32'hBAD1BAD1) begin n_fail++; $display("FAIL to_dload: got %h want bad1bad1", dload_a); end
        n_cmp++; if (bus_err_a !== 1'b0) begin n_fail++; $display("FAIL to_buserr_early: got %b want 0", bus_err_a); end
      end
    end
    @(posedge CLK); #1;
    dREN = 0;
    @(negedge CLK);
    n_cmp++; if (bus_err_a !== 1'b1) begin n_fail++; $display("FAIL to_buserr_set: got %b want 1", bus_err_a); end
    n_cmp++; if (ram_ren_a !== 1'b0) begin n_fail++; $display("FAIL to_idle_ren: got %b want 0", ram_ren_a); end
    // a later good transaction leaves the sticky error in place
    dREN = 1; daddr = 32'h500;
    @(posedge CLK); #1;
    man_ack = 1; ram_load = 32'hCAFEF00D;
    @(negedge CLK);
    n_cmp++; if (dload_a !== 32'hCAFEF00D) begin n_fail++; $display("FAIL good_dload: got %h want cafef00d", dload_a); end
    @(posedge CLK); #1;
    dREN = 0; man_ack = 0;
    @(negedge CLK);
    n_cmp++; if (bus_err_a !== 1'b1) begin n_fail++; $display("FAIL buserr_sticky: got %b want 1", bus_err_a); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_lone_fetch();
    test_priority();
    test_write_wins();
    test_starvation();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
